prog_sequencer: RTL and testbench

Run controller that sequences the processor core through its three benchmark programs (P1, P2, P3) using the core's Start/Ack handshake. It sits beside `TopLevel` and drives the core's start pulse and program base address, then waits for the done flag. It records per-program cycle counts, can pause between programs so data memory can be checked, and flags programs that never finish.

---
 rtl/prog_seq_pkg.sv | 18 +
 rtl/run_timer.sv | 48 ++++
 rtl/prog_sequencer.sv | 141 ++++++++++++++
 tb/tb_prog_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared types and default constants for the benchmark run sequencer.
// The state enum is exported so that the debug port and the bench use one encoding.
package prog_seq_pkg;

   localparam int DEF_NUM_PROGS   = 3;
   localparam int DEF_PC_W        = 10;
   localparam int DEF_CYC_W       = 16;
   localparam int DEF_TIMEOUT_CYC = 50000;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      RUN    = 3'd2,
      PAUSE  = 3'd3,
      FAULT  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/run_timer.sv
// Core-ack edge detector plus run-length counter used by prog_sequencer.
// The counter is cleared while the core is being launched and advances once per run cycle.
module run_timer #(
   parameter int CYC_W       = 16,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             core_ack_i,
   input  logic             clear_i,
   input  logic             enable_i,
   output logic             ack_edge_o,
   output logic [CYC_W-1:0] count_o,
   output logic             timeout_hit_o
);

   // The count holds (run cycles - 1), so the limit is hit on the TIMEOUT_CYC-th run cycle.
   localparam logic [CYC_W-1:0] LIMIT = CYC_W'(TIMEOUT_CYC - 1);

   logic             ack_q;
   logic [CYC_W-1:0] count_q;
   logic [CYC_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ack_q   <= 1'b0;
         count_q <= '0;
      end else begin
         ack_q   <= core_ack_i;
         count_q <= count_d;
      end
   end

   // A level still high from the previous program never produces an edge.
   assign ack_edge_o    = core_ack_i & ~ack_q;
   assign count_o       = count_q;
   assign timeout_hit_o = (count_q == LIMIT);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller that launches the core's benchmark programs one after another,
// reports each program's run length and flags a program that never acknowledges.
module prog_sequencer
   import prog_seq_pkg::*;
#(
   parameter int NUM_PROGS   = DEF_NUM_PROGS,
   parameter int PC_W        = DEF_PC_W,
   parameter int CYC_W       = DEF_CYC_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         Go,
   input  logic                         Advance,
   input  logic [NUM_PROGS*PC_W-1:0]    BaseAddr,
   input  logic                         CoreAck,
   output logic                         CoreStart,
   output logic [PC_W-1:0]              CoreBase,
   output logic [$clog2(NUM_PROGS)-1:0] ProgIdx,
   output logic [CYC_W-1:0]             CycCount,
   output logic                         CycValid,
   output logic                         Busy,
   output logic                         Done,
   output logic                         Timeout,
   output seq_state_t                   DbgState
);

   localparam int              IDX_W    = $clog2(NUM_PROGS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PROGS - 1);

   seq_state_t       state_q;
   logic [IDX_W-1:0] idx_q;
   logic [PC_W-1:0]  base_q;
   logic [CYC_W-1:0] cyc_q;
   logic             start_q;
   logic             valid_q;
   logic             done_q;
   logic             busy_q;
   logic             timeout_q;

   logic             ack_edge;
   logic             timeout_hit;
   logic [CYC_W-1:0] run_count;
   logic [IDX_W-1:0] next_idx;
   logic [PC_W-1:0]  first_base;
   logic [PC_W-1:0]  next_base;

   run_timer #(
      .CYC_W       (CYC_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_run_timer (
      .Clk           (Clk),
      .Reset         (Reset),
      .core_ack_i    (CoreAck),
      .clear_i       (state_q == LAUNCH),
      .enable_i      (state_q == RUN),
      .ack_edge_o    (ack_edge),
      .count_o       (run_count),
      .timeout_hit_o (timeout_hit)
   );

   always_comb begin
      next_idx   = idx_q + 1'b1;
      first_base = BaseAddr[PC_W-1:0];
      next_base  = BaseAddr[int'(next_idx)*PC_W +: PC_W];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         base_q    <= '0;
         cyc_q     <= '0;
         start_q   <= 1'b0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         start_q <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE, FAULT: begin
               if (Go) begin
                  state_q   <= LAUNCH;
                  idx_q     <= '0;
                  base_q    <= first_base;
                  start_q   <= 1'b1;
                  busy_q    <= 1'b1;
                  timeout_q <= 1'b0;
               end
            end
            LAUNCH: begin
               state_q <= RUN;
            end
            RUN: begin
               // Completion takes priority over a limit reached in the same cycle.
               if (ack_edge) begin
                  cyc_q   <= run_count + 1'b1;
                  valid_q <= 1'b1;
                  if (idx_q == LAST_IDX) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= PAUSE;
                  end
               end else if (timeout_hit) begin
                  state_q   <= FAULT;
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            PAUSE: begin
               if (Advance) begin
                  state_q <= LAUNCH;
                  idx_q   <= next_idx;
                  base_q  <= next_base;
                  start_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign CoreStart = start_q;
   assign CoreBase  = base_q;
   assign ProgIdx   = idx_q;
   assign CycCount  = cyc_q;
   assign CycValid  = valid_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Timeout   = timeout_q;
   assign DbgState  = state_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scenario bench for prog_sequencer: a small core model answers each launch after a
// chosen number of run cycles and results are compared against model-derived values.
`timescale 1ns/1ps
module tb_prog_sequencer;
   import prog_seq_pkg::*;

   localparam int NP   = 3;
   localparam int PC_W = 10;
   localparam int CW   = 16;
   localparam int TO   = 100;

   logic             Clk = 1'b0;
   logic             Reset, Go, Advance, CoreAck;
   logic [NP*PC_W-1:0] BaseAddr;
   logic             CoreStart;
   logic [PC_W-1:0]  CoreBase;
   logic [1:0]       ProgIdx;
   logic [CW-1:0]    CycCount;
   logic             CycValid, Busy, Done, Timeout;
   seq_state_t       DbgState;

   int total  = 0;
   int passed = 0;

   // Reference model: program start addresses and a queue of expected run lengths.
   logic [PC_W-1:0] exp_base [NP];
   logic [CW-1:0]   exp_q[$];

   prog_sequencer #(
      .NUM_PROGS(NP), .PC_W(PC_W), .CYC_W(CW), .TIMEOUT_CYC(TO)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Go(Go), .Advance(Advance), .BaseAddr(BaseAddr),
      .CoreAck(CoreAck), .CoreStart(CoreStart), .CoreBase(CoreBase), .ProgIdx(ProgIdx),
      .CycCount(CycCount), .CycValid(CycValid), .Busy(Busy), .Done(Done),
      .Timeout(Timeout), .DbgState(DbgState)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   task automatic set_bases(input logic [PC_W-1:0] a0, a1, a2);
      exp_base[0] = a0;
      exp_base[1] = a1;
      exp_base[2] = a2;
      BaseAddr = {a2, a1, a0};
   endtask

   task automatic do_reset(input int cycles);
      Reset = 1'b1;
      repeat (cycles) @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic pulse_go();
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
   endtask

   task automatic pulse_advance();
      Advance = 1'b1;
      @(negedge Clk);
      Advance = 1'b0;
   endtask

   // Core model: waits for the launch, keeps Ack high for the first `hold` run cycles,
   // then raises Ack on run cycle n. Reports what the sequencer showed around that.
   task automatic drive_program(input int n, input int hold,
                                output bit got_start, output logic [PC_W-1:0] base_seen,
                                output logic [1:0] idx_seen, output logic start_after,
                                output int early, output logic valid_seen,
                                output logic [CW-1:0] cyc_seen, output logic done_seen,
                                output logic pulse_after, output logic busy_after,
                                output seq_state_t state_after);
      got_start = 1'b0; base_seen = 'x; idx_seen = 'x; start_after = 1'bx; early = 0;
      valid_seen = 1'bx; cyc_seen = 'x; done_seen = 1'bx; pulse_after = 1'bx;
      busy_after = 1'bx; state_after = IDLE;
      for (int w = 0; w < 20; w++) begin
         if (CoreStart === 1'b1) begin
            got_start = 1'b1;
            break;
         end
         @(negedge Clk);
      end
      if (!got_start) return;
      base_seen = CoreBase;
      idx_seen  = ProgIdx;
      for (int i = 1; i <= n; i++) begin
         @(negedge Clk);
         if (i == 1) start_after = CoreStart;
         if (CycValid !== 1'b0 || Done !== 1'b0) early++;
         CoreAck = (i <= hold) || (i == n);
      end
      @(negedge Clk);
      valid_seen = CycValid;
      cyc_seen   = CycCount;
      done_seen  = Done;
      CoreAck    = 1'b0;
      @(negedge Clk);
      pulse_after = CycValid | Done;
      busy_after  = Busy;
      state_after = DbgState;
   endtask

   bit               g_start;
   logic [PC_W-1:0]  g_base;
   logic [1:0]       g_idx;
   logic             g_sa, g_valid, g_done, g_pa, g_busy;
   int               g_early;
   logic [CW-1:0]    g_cyc;
   seq_state_t       g_state;

   task automatic test_reset();
      do_reset(3);
      total++; if (CoreStart !== 1'b0) $display("FAIL reset_corestart got %b want 0", CoreStart); else passed++;
      total++; if (CycValid !== 1'b0) $display("FAIL reset_cycvalid got %b want 0", CycValid); else passed++;
      total++; if (Done !== 1'b0) $display("FAIL reset_done got %b want 0", Done); else passed++;
      total++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy); else passed++;
      total++; if (Timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", Timeout); else passed++;
      total++; if (ProgIdx !== 2'd0) $display("FAIL reset_progidx got %0d want 0", ProgIdx); else passed++;
      total++; if (CoreBase !== '0) $display("FAIL reset_corebase got %h want 0", CoreBase); else passed++;
      total++; if (CycCount !== '0) $display("FAIL reset_cyccount got %0d want 0", CycCount); else passed++;
      total++; if (DbgState !== IDLE) $display("FAIL reset_state got %0d want %0d", DbgState, IDLE); else passed++;
   endtask

   task automatic test_single();
      do_reset(1);
      set_bases(PC_W'($urandom_range(0, 1023)), PC_W'($urandom_range(0, 1023)), PC_W'($urandom_range(0, 1023)));
      pulse_go();
      total++; if (CoreStart !== 1'b1) $display("FAIL single_start_latency got %b want 1", CoreStart); else passed++;
      drive_program(20, 0, g_start, g_base, g_idx, g_sa, g_early, g_valid, g_cyc, g_done, g_pa, g_busy, g_state);
      total++; if (g_base !== exp_base[0]) $display("FAIL single_base got %h want %h", g_base, exp_base[0]); else passed++;
      total++; if (g_sa !== 1'b0) $display("FAIL single_start_width got %b want 0 on second cycle", g_sa); else passed++;
      total++; if (g_early !== 0) $display("FAIL single_early got %0d want 0", g_early); else passed++;
      total++; if (g_valid !== 1'b1) $display("FAIL single_valid got %b want 1", g_valid); else passed++;
      total++; if (g_cyc !== 16'd20) $display("FAIL single_cyccount got %0d want 20", g_cyc); else passed++;
      total++; if (g_done !== 1'b0) $display("FAIL single_done got %b want 0", g_done); else passed++;
      total++; if (g_busy !== 1'b1) $display("FAIL single_busy got %b want 1", g_busy); else passed++;
      total++; if (g_state !== PAUSE) $display("FAIL single_state got %0d want %0d", g_state, PAUSE); else passed++;
   endtask

   task automatic test_full_sequence();
      int lens [NP];
      lens[0] = 20; lens[1] = 35; lens[2] = 7;
      do_reset(1);
      set_bases(10'h000, 10'h100, 10'h200);
      pulse_go();
      for (int k = 0; k < NP; k++) begin
         drive_program(lens[k], 0, g_start, g_base, g_idx, g_sa, g_early, g_valid, g_cyc, g_done, g_pa, g_busy, g_state);
         total++; if (g_start !== 1'b1) $display("FAIL seq_start%0d got %b want 1", k, g_start); else passed++;
         total++; if (g_base !== exp_base[k]) $display("FAIL seq_base%0d got %h want %h", k, g_base, exp_base[k]); else passed++;
         total++; if (g_idx !== 2'(k)) $display("FAIL seq_idx%0d got %0d want %0d", k, g_idx, k); else passed++;
         total++; if (g_cyc !== CW'(lens[k])) $display("FAIL seq_cyc%0d got %0d want %0d", k, g_cyc, lens[k]); else passed++;
         total++; if (g_early !== 0 || g_pa !== 1'b0) $display("FAIL seq_pulses%0d got early=%0d after=%b want 0/0", k, g_early, g_pa); else passed++;
         total++; if (g_done !== (k == NP - 1)) $display("FAIL seq_done%0d got %b want %b", k, g_done, (k == NP - 1)); else passed++;
         if (k < NP - 1) begin
            total++; if (g_state !== PAUSE || g_busy !== 1'b1) $display("FAIL seq_pause%0d got state=%0d busy=%b want %0d/1", k, g_state, g_busy, PAUSE); else passed++;
            pulse_advance();
            total++; if (CoreStart !== 1'b1) $display("FAIL seq_adv_latency%0d got %b want 1", k, CoreStart); else passed++;
         end
      end
      total++; if (g_state !== IDLE || g_busy !== 1'b0) $display("FAIL seq_end_state got state=%0d busy=%b want %0d/0", g_state, g_busy, IDLE); else passed++;
      total++; if (ProgIdx !== 2'd2) $display("FAIL seq_end_idx got %0d want 2", ProgIdx); else passed++;
   endtask

   task automatic test_ack_held();
      do_reset(1);
      CoreAck = 1'b1;
      pulse_go();
      drive_program(16, 5, g_start, g_base, g_idx, g_sa, g_early, g_valid, g_cyc, g_done, g_pa, g_busy, g_state);
      total++; if (g_early !== 0) $display("FAIL held_early got %0d want 0", g_early); else passed++;
      total++; if (g_valid !== 1'b1) $display("FAIL held_valid got %b want 1", g_valid); else passed++;
      total++; if (g_cyc !== 16'd16) $display("FAIL held_cyccount got %0d want 16", g_cyc); else passed++;
      total++; if (g_state !== PAUSE) $display("FAIL held_state got %0d want %0d", g_state, PAUSE); else passed++;
   endtask

   task automatic test_timeout();
      do_reset(1);
      set_bases(10'h03c, 10'h155, 10'h2aa);
      pulse_go();
      for (int i = 1; i <= TO + 1; i++) begin
         @(negedge Clk);
         if (i == TO) begin
            total++; if (Timeout !== 1'b0 || DbgState !== RUN) $display("FAIL to_before got timeout=%b state=%0d want 0/%0d", Timeout, DbgState, RUN); else passed++;
         end
         if (i == TO + 1) begin
            total++; if (Timeout !== 1'b1) $display("FAIL to_flag got %b want 1", Timeout); else passed++;
            total++; if (DbgState !== FAULT || Busy !== 1'b0) $display("FAIL to_state got state=%0d busy=%b want %0d/0", DbgState, Busy, FAULT); else passed++;
         end
      end
      pulse_advance();
      repeat (2) @(negedge Clk);
      total++; if (DbgState !== FAULT || CoreStart !== 1'b0 || Timeout !== 1'b1) $display("FAIL to_advance_ignored got state=%0d start=%b timeout=%b want %0d/0/1", DbgState, CoreStart, Timeout, FAULT); else passed++;
      pulse_go();
      total++; if (CoreStart !== 1'b1 || Timeout !== 1'b0) $display("FAIL to_relaunch got start=%b timeout=%b want 1/0", CoreStart, Timeout); else passed++;
      total++; if (ProgIdx !== 2'd0 || CoreBase !== exp_base[0]) $display("FAIL to_relaunch_base got idx=%0d base=%h want 0/%h", ProgIdx, CoreBase, exp_base[0]); else passed++;
      drive_program(7, 0, g_start, g_base, g_idx, g_sa, g_early, g_valid, g_cyc, g_done, g_pa, g_busy, g_state);
      total++; if (g_cyc !== 16'd7 || g_valid !== 1'b1) $display("FAIL to_after_cyc got %0d valid=%b want 7/1", g_cyc, g_valid); else passed++;
   endtask

   task automatic test_ack_at_limit();
      do_reset(1);
      pulse_go();
      drive_program(TO, 0, g_start, g_base, g_idx, g_sa, g_early, g_valid, g_cyc, g_done, g_pa, g_busy, g_state);
      total++; if (g_valid !== 1'b1 || g_cyc !== CW'(TO)) $display("FAIL limit_cyc got %0d valid=%b want %0d/1", g_cyc, g_valid, TO); else passed++;
      total++; if (g_state !== PAUSE || Timeout !== 1'b0) $display("FAIL limit_state got state=%0d timeout=%b want %0d/0", g_state, Timeout, PAUSE); else passed++;
   endtask

   task automatic test_reset_mid_run();
      int stray;
      do_reset(1);
      pulse_go();
      drive_program(12, 0, g_start, g_base, g_idx, g_sa, g_early, g_valid, g_cyc, g_done, g_pa, g_busy, g_state);
      pulse_advance();
      repeat (3) @(negedge Clk);
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      Advance = 1'b1;
      @(negedge Clk);
      Advance = 1'b0;
      @(negedge Clk);
      total++; if (DbgState !== RUN || CoreStart !== 1'b0 || ProgIdx !== 2'd1) $display("FAIL stray_ignored got state=%0d start=%b idx=%0d want %0d/0/1", DbgState, CoreStart, ProgIdx, RUN); else passed++;
      do_reset(1);
      total++; if (DbgState !== IDLE || Busy !== 1'b0 || CoreStart !== 1'b0) $display("FAIL midreset_ctrl got state=%0d busy=%b start=%b want %0d/0/0", DbgState, Busy, CoreStart, IDLE); else passed++;
      total++; if (ProgIdx !== 2'd0 || CoreBase !== '0 || CycCount !== '0) $display("FAIL midreset_regs got idx=%0d base=%h cyc=%0d want 0/0/0", ProgIdx, CoreBase, CycCount); else passed++;
      stray = 0;
      CoreAck = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         if (CycValid !== 1'b0 || Done !== 1'b0 || DbgState !== IDLE) stray++;
      end
      CoreAck = 1'b0;
      total++; if (stray !== 0) $display("FAIL midreset_no_report got %0d stray cycles want 0", stray); else passed++;
   endtask

   task automatic test_random();
      logic [CW-1:0] want;
      for (int r = 0; r < 4; r++) begin
         set_bases(PC_W'($urandom_range(0, 1023)), PC_W'($urandom_range(0, 1023)), PC_W'($urandom_range(0, 1023)));
         repeat ($urandom_range(0, 3)) @(negedge Clk);
         pulse_go();
         for (int k = 0; k < NP; k++) begin
            int n;
            n = $urandom_range(1, 90);
            exp_q.push_back(CW'(n));
            drive_program(n, 0, g_start, g_base, g_idx, g_sa, g_early, g_valid, g_cyc, g_done, g_pa, g_busy, g_state);
            want = exp_q.pop_front();
            total++; if (g_base !== exp_base[k]) $display("FAIL rnd_base r%0d k%0d got %h want %h", r, k, g_base, exp_base[k]); else passed++;
            total++; if (g_valid !== 1'b1 || g_cyc !== want) $display("FAIL rnd_cyc r%0d k%0d got %0d valid=%b want %0d", r, k, g_cyc, g_valid, want); else passed++;
            total++; if (g_done !== (k == NP - 1) || g_early !== 0) $display("FAIL rnd_done r%0d k%0d got done=%b early=%0d", r, k, g_done, g_early); else passed++;
            if (k < NP - 1) begin
               repeat ($urandom_range(0, 4)) @(negedge Clk);
               pulse_advance();
            end
         end
         total++; if (DbgState !== IDLE || ProgIdx !== 2'd2) $display("FAIL rnd_end r%0d got state=%0d idx=%0d want %0d/2", r, DbgState, ProgIdx, IDLE); else passed++;
      end
   endtask

   initial begin
      Reset = 1'b1; Go = 1'b0; Advance = 1'b0; CoreAck = 1'b0; BaseAddr = '0;
      @(negedge Clk);
      test_reset();
      test_single();
      test_full_sequence();
      test_ack_held();
      test_timeout();
      test_ack_at_limit();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
